// File: rtl/alu_mc.sv
// alu_mc: handshaked multi-cycle ALU. Single-cycle ops load the output
// register on the accepting edge; divide runs an iterative restoring unit
// (one quotient bit per cycle) and then applies operand signs.
module alu_mc #(
    parameter int BUS_WIDTH         = 64,
    parameter int ALU_CONTROL_WIDTH = 2,
    parameter int ALU_SELECT_WIDTH  = 3,
    parameter int TAG_WIDTH         = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [BUS_WIDTH-1:0]         in1,
    input  logic [BUS_WIDTH-1:0]         in2,
    input  logic [ALU_CONTROL_WIDTH-1:0] control,
    input  logic [ALU_SELECT_WIDTH-1:0]  select,
    input  logic [TAG_WIDTH-1:0]         in_tag,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [BUS_WIDTH-1:0]         out,
    output logic [TAG_WIDTH-1:0]         out_tag,
    output logic                         busy
);

    localparam int W  = BUS_WIDTH;
    localparam int SW = $clog2(BUS_WIDTH);
    localparam logic [SW-1:0] LAST_STEP = SW'(BUS_WIDTH - 1);

    localparam logic [ALU_SELECT_WIDTH-1:0] SEL_ADD = ALU_SELECT_WIDTH'(0);
    localparam logic [ALU_SELECT_WIDTH-1:0] SEL_MUL = ALU_SELECT_WIDTH'(1);
    localparam logic [ALU_SELECT_WIDTH-1:0] SEL_DIV = ALU_SELECT_WIDTH'(2);
    localparam logic [ALU_SELECT_WIDTH-1:0] SEL_SLL = ALU_SELECT_WIDTH'(3);
    localparam logic [ALU_SELECT_WIDTH-1:0] SEL_SR  = ALU_SELECT_WIDTH'(4);
    localparam logic [ALU_SELECT_WIDTH-1:0] SEL_XOR = ALU_SELECT_WIDTH'(5);
    localparam logic [ALU_SELECT_WIDTH-1:0] SEL_OR  = ALU_SELECT_WIDTH'(6);
    localparam logic [ALU_SELECT_WIDTH-1:0] SEL_AND = ALU_SELECT_WIDTH'(7);

    localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

    typedef enum logic {
        IDLE = 1'b0,
        DIV  = 1'b1
    } state_t;

    state_t         state_reg;
    logic [SW-1:0]  count_reg;
    logic           done_reg;      // all W restoring steps taken, result pending
    logic [W-1:0]   quo_reg;       // dividend shifts out, quotient shifts in
    logic [W-1:0]   rem_reg;
    logic [W-1:0]   divisor_reg;
    logic           q_neg_reg;
    logic           r_neg_reg;
    logic           rem_sel_reg;
    logic [TAG_WIDTH-1:0] div_tag_reg;

    // ---------------- single-cycle datapath ----------------
    logic [2*W-1:0] mul_a, mul_b, mul_full;
    logic [SW-1:0]  shamt;
    logic [W-1:0]   alu_result;

    assign shamt = in2[SW-1:0];

    // Extend multiplier operands according to the requested signedness
    always_comb begin
        mul_a = {{W{1'b0}}, in1};
        mul_b = {{W{1'b0}}, in2};
        if (control[1:0] == 2'b01 || control[1:0] == 2'b10)
            mul_a = {{W{in1[W-1]}}, in1};
        if (control[1:0] == 2'b01)
            mul_b = {{W{in2[W-1]}}, in2};
    end

    assign mul_full = mul_a * mul_b;

    // Result mux for every operation that completes in one cycle
    always_comb begin
        alu_result = '0;
        case (select)
            SEL_ADD: alu_result = control[0] ? (in1 - in2) : (in1 + in2);
            SEL_MUL: alu_result = (control[1:0] == 2'b00) ? mul_full[W-1:0] : mul_full[2*W-1:W];
            SEL_SLL: alu_result = in1 << shamt;
            SEL_SR:  alu_result = control[0] ? $unsigned($signed(in1) >>> shamt) : (in1 >> shamt);
            SEL_XOR: alu_result = in1 ^ in2;
            SEL_OR:  alu_result = in1 | in2;
            SEL_AND: alu_result = in1 & in2;
            default: alu_result = '0;
        endcase
    end

    // ---------------- divide front end ----------------
    logic         is_div, div_signed, div_rem, div_zero, div_ovf;
    logic [W-1:0] abs_a, abs_b, special_result;

    assign is_div     = (select == SEL_DIV);
    assign div_signed = ~control[0];
    assign div_rem    = control[1];
    assign div_zero   = (in2 == '0);
    assign div_ovf    = div_signed && (in1 == MOST_NEG) && (in2 == '1);
    assign abs_a      = (div_signed && in1[W-1]) ? (~in1 + 1'b1) : in1;
    assign abs_b      = (div_signed && in2[W-1]) ? (~in2 + 1'b1) : in2;

    // Results that need no iteration: divide by zero and signed overflow
    always_comb begin
        if (div_zero)
            special_result = div_rem ? in1 : '1;
        else
            special_result = div_rem ? '0 : in1;
    end

    // ---------------- restoring step ----------------
    logic [W:0]   shifted, diff;
    logic [W-1:0] step_rem, step_quo;
    logic [W-1:0] fin_q, fin_r, fin_result;

    assign shifted = {rem_reg, quo_reg[W-1]};
    assign diff    = shifted - {1'b0, divisor_reg};

    // Keep the trial subtraction only when it did not go negative
    always_comb begin
        if (!diff[W]) begin
            step_rem = diff[W-1:0];
            step_quo = {quo_reg[W-2:0], 1'b1};
        end else begin
            step_rem = shifted[W-1:0];
            step_quo = {quo_reg[W-2:0], 1'b0};
        end
    end

    assign fin_q      = q_neg_reg ? (~quo_reg + 1'b1) : quo_reg;
    assign fin_r      = r_neg_reg ? (~rem_reg + 1'b1) : rem_reg;
    assign fin_result = rem_sel_reg ? fin_r : fin_q;

    assign in_ready = (state_reg == IDLE) && (!out_valid || out_ready);
    assign busy     = (state_reg == DIV);

    // Control FSM, divider iteration and output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            count_reg   <= '0;
            done_reg    <= 1'b0;
            quo_reg     <= '0;
            rem_reg     <= '0;
            divisor_reg <= '0;
            q_neg_reg   <= 1'b0;
            r_neg_reg   <= 1'b0;
            rem_sel_reg <= 1'b0;
            div_tag_reg <= '0;
            out         <= '0;
            out_tag     <= '0;
            out_valid   <= 1'b0;
        end else begin
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        if (!is_div) begin
                            out       <= alu_result;
                            out_tag   <= in_tag;
                            out_valid <= 1'b1;
                        end else if (div_zero || div_ovf) begin
                            out       <= special_result;
                            out_tag   <= in_tag;
                            out_valid <= 1'b1;
                        end else begin
                            quo_reg     <= abs_a;
                            divisor_reg <= abs_b;
                            rem_reg     <= '0;
                            q_neg_reg   <= div_signed && (in1[W-1] ^ in2[W-1]);
                            r_neg_reg   <= div_signed && in1[W-1];
                            rem_sel_reg <= div_rem;
                            div_tag_reg <= in_tag;
                            count_reg   <= '0;
                            done_reg    <= 1'b0;
                            state_reg   <= DIV;
                        end
                    end
                end
                DIV: begin
                    if (!done_reg) begin
                        rem_reg <= step_rem;
                        quo_reg <= step_quo;
                        if (count_reg == LAST_STEP)
                            done_reg <= 1'b1;
                        else
                            count_reg <= count_reg + SW'(1);
                    end else if (!out_valid || out_ready) begin
                        // Hold at the final count until the output register frees up
                        out       <= fin_result;
                        out_tag   <= div_tag_reg;
                        out_valid <= 1'b1;
                        count_reg <= '0;
                        done_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Directed testbench for alu_mc with hand-computed expected results.
module tb_alu_mc;

    localparam int W = 64;
    localparam logic [W-1:0] ONES     = '1;
    localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in1, in2;
    logic [1:0]   control;
    logic [2:0]   select;
    logic [3:0]   in_tag;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out;
    logic [3:0]   out_tag;
    logic         busy;

    int checks = 0;
    int errors = 0;

    alu_mc #(
        .BUS_WIDTH(W),
        .ALU_CONTROL_WIDTH(2),
        .ALU_SELECT_WIDTH(3),
        .TAG_WIDTH(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in1(in1),
        .in2(in2),
        .control(control),
        .select(select),
        .in_tag(in_tag),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out(out),
        .out_tag(out_tag),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] sel, input logic [1:0] ctl,
                         input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] tag);
        in_valid = 1'b1;
        select   = sel;
        control  = ctl;
        in1      = a;
        in2      = b;
        in_tag   = tag;
    endtask

    // Issue a divide and wait for its result; wait_edges counts edges after acceptance
    task automatic run_div(input string name, input logic [1:0] ctl, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [W-1:0] exp,
                           input logic [3:0] tag, input int wait_edges);
        int  cyc;
        bit  busy_ok;
        drive(3'b010, ctl, a, b, tag);
        check_val({name, "_in_ready"}, W'(in_ready), W'(1));
        tick();
        in_valid = 1'b0;
        cyc = 0;
        busy_ok = 1'b1;
        while (!out_valid && cyc < 200) begin
            if (!busy) busy_ok = 1'b0;
            tick();
            cyc++;
        end
        $display("div %s tag=%0d out=%h edges=%0d", name, out_tag, out, cyc);
        check_val({name, "_edges"}, W'(cyc), W'(wait_edges));
        check_val({name, "_busy_held"}, W'(busy_ok), W'(1));
        check_val({name, "_busy_low"}, W'(busy), W'(0));
        check_val({name, "_out"}, out, exp);
        check_val({name, "_tag"}, W'(out_tag), W'(tag));
    endtask

    typedef struct {
        string        name;
        logic [2:0]   sel;
        logic [1:0]   ctl;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp;
        logic [3:0]   tag;
    } vec_t;

    vec_t vecs[$];

    initial begin
        bit quiet;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in1 = '0; in2 = '0; control = '0; select = '0; in_tag = '0;

        // Reset state
        repeat (3) tick();
        check_val("rst_out_valid", W'(out_valid), W'(0));
        check_val("rst_out", out, '0);
        check_val("rst_out_tag", W'(out_tag), W'(0));
        check_val("rst_busy", W'(busy), W'(0));
        rst_n = 1'b1;
        tick();
        check_val("rst_in_ready", W'(in_ready), W'(1));

        // Back-to-back single-cycle ops, one result per cycle
        vecs.push_back('{"add",    3'b000, 2'b00, 64'd5, 64'd7, 64'd12, 4'd1});
        vecs.push_back('{"sub",    3'b000, 2'b01, 64'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 4'd2});
        vecs.push_back('{"sra",    3'b100, 2'b01, MOST_NEG, 64'd63, ONES, 4'd3});
        vecs.push_back('{"mulhss", 3'b001, 2'b01, ONES, ONES, 64'd0, 4'd4});
        vecs.push_back('{"mullo",  3'b001, 2'b00, 64'd6, 64'd7, 64'd42, 4'd5});
        vecs.push_back('{"mulhuu", 3'b001, 2'b11, ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE, 4'd6});
        vecs.push_back('{"mulhsu", 3'b001, 2'b10, ONES, 64'd2, ONES, 4'd7});
        vecs.push_back('{"sll",    3'b011, 2'b00, 64'd1, 64'd68, 64'd16, 4'd8});
        vecs.push_back('{"srl",    3'b100, 2'b00, MOST_NEG, 64'd63, 64'd1, 4'd9});
        vecs.push_back('{"xor",    3'b101, 2'b00, 64'hF0, 64'hFF, 64'h0F, 4'd10});
        vecs.push_back('{"or",     3'b110, 2'b00, 64'hF0, 64'h0F, 64'hFF, 4'd11});
        vecs.push_back('{"and",    3'b111, 2'b00, 64'hF0, 64'h3C, 64'h30, 4'd12});

        foreach (vecs[i]) begin
            check_val({vecs[i].name, "_in_ready"}, W'(in_ready), W'(1));
            drive(vecs[i].sel, vecs[i].ctl, vecs[i].a, vecs[i].b, vecs[i].tag);
            tick();
            $display("op %s tag=%0d out=%h", vecs[i].name, out_tag, out);
            check_val({vecs[i].name, "_valid"}, W'(out_valid), W'(1));
            check_val({vecs[i].name, "_out"}, out, vecs[i].exp);
            check_val({vecs[i].name, "_tag"}, W'(out_tag), W'(vecs[i].tag));
        end
        in_valid = 1'b0;
        tick();
        check_val("drain_valid", W'(out_valid), W'(0));

        // Iterative divides: result W+1 edges after acceptance
        run_div("sdiv_m7_2",  2'b00, -64'sd7, 64'd2, -64'sd3, 4'd1, W + 1);
        tick();
        run_div("srem_m7_2",  2'b10, -64'sd7, 64'd2, ONES, 4'd2, W + 1);
        tick();
        run_div("udiv_100_7", 2'b01, 64'd100, 64'd7, 64'd14, 4'd3, W + 1);
        tick();
        run_div("urem_100_7", 2'b11, 64'd100, 64'd7, 64'd2, 4'd4, W + 1);
        tick();
        run_div("sdiv_7_m2",  2'b00, 64'd7, -64'sd2, -64'sd3, 4'd5, W + 1);
        tick();
        run_div("srem_7_m2",  2'b10, 64'd7, -64'sd2, 64'd1, 4'd6, W + 1);
        tick();
        run_div("udiv_max_1", 2'b01, ONES, 64'd1, ONES, 4'd7, W + 1);
        tick();
        run_div("udiv_min_max", 2'b01, MOST_NEG, ONES, 64'd0, 4'd8, W + 1);
        tick();

        // Special cases load on the accepting edge with no busy pulse
        run_div("sdiv_by0", 2'b00, 64'd9, 64'd0, ONES, 4'd9, 0);
        tick();
        run_div("srem_by0", 2'b10, 64'd9, 64'd0, 64'd9, 4'd10, 0);
        tick();
        run_div("udiv_by0", 2'b01, 64'd9, 64'd0, ONES, 4'd11, 0);
        tick();
        run_div("urem_by0", 2'b11, 64'd9, 64'd0, 64'd9, 4'd12, 0);
        tick();
        run_div("sdiv_ovf", 2'b00, MOST_NEG, ONES, MOST_NEG, 4'd13, 0);
        tick();
        run_div("srem_ovf", 2'b10, MOST_NEG, ONES, 64'd0, 4'd14, 0);
        tick();

        // Back-pressure on a single-cycle result
        out_ready = 1'b0;
        drive(3'b000, 2'b00, 64'd20, 64'd22, 4'd5);
        tick();
        $display("op bp_add tag=%0d out=%h", out_tag, out);
        check_val("bp_add_out", out, 64'd42);
        drive(3'b101, 2'b00, 64'hF0, 64'hFF, 4'd6);
        check_val("bp_in_ready_low", W'(in_ready), W'(0));
        repeat (3) tick();
        check_val("bp_hold_out", out, 64'd42);
        check_val("bp_hold_tag", W'(out_tag), W'(5));
        check_val("bp_hold_valid", W'(out_valid), W'(1));
        check_val("bp_hold_in_ready", W'(in_ready), W'(0));
        out_ready = 1'b1;
        #1;
        check_val("bp_in_ready_high", W'(in_ready), W'(1));
        tick();
        in_valid = 1'b0;
        $display("op bp_xor tag=%0d out=%h", out_tag, out);
        check_val("bp_swap_out", out, 64'h0F);
        check_val("bp_swap_tag", W'(out_tag), W'(6));
        check_val("bp_swap_valid", W'(out_valid), W'(1));
        tick();
        check_val("bp_drain_valid", W'(out_valid), W'(0));

        // Divide completing while the consumer is stalled
        out_ready = 1'b0;
        run_div("bp_udiv", 2'b01, 64'd100, 64'd7, 64'd14, 4'd7, W + 1);
        repeat (3) tick();
        check_val("bp_div_hold_out", out, 64'd14);
        check_val("bp_div_hold_valid", W'(out_valid), W'(1));
        check_val("bp_div_in_ready", W'(in_ready), W'(0));
        out_ready = 1'b1;
        tick();
        check_val("bp_div_drain", W'(out_valid), W'(0));

        // Reset in the middle of a divide aborts it
        drive(3'b010, 2'b00, -64'sd7, 64'd2, 4'd8);
        tick();
        in_valid = 1'b0;
        repeat (30) tick();
        check_val("mid_busy_before", W'(busy), W'(1));
        rst_n = 1'b0;
        #1;
        check_val("mid_busy_reset", W'(busy), W'(0));
        check_val("mid_valid_reset", W'(out_valid), W'(0));
        check_val("mid_out_reset", out, '0);
        tick();
        rst_n = 1'b1;
        quiet = 1'b1;
        for (int i = 0; i < W + 8; i++) begin
            tick();
            if (out_valid || busy) quiet = 1'b0;
        end
        check_val("mid_no_result", W'(quiet), W'(1));
        drive(3'b000, 2'b00, 64'd1, 64'd2, 4'd9);
        tick();
        in_valid = 1'b0;
        $display("op post_rst_add tag=%0d out=%h", out_tag, out);
        check_val("post_rst_valid", W'(out_valid), W'(1));
        check_val("post_rst_out", out, 64'd3);
        check_val("post_rst_tag", W'(out_tag), W'(9));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
